// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared types and constants for the pipeline hazard sequencer
package hazard_stall_controller_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MD_BUSY   = 2'd1,
    ST_DMEM_WAIT = 2'd2
  } hsc_state_e;

  typedef struct packed {
    logic md_start;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic bubble_ex;
    logic bubble_mem;
    logic bubble_wb;
  } hsc_ctrl_t;

endpackage

// File: rtl/hazard_load_use_detect.sv
// rtl/hazard_load_use_detect.sv - load-use dependence comparator between ID operands and EX load
module hazard_load_use_detect
  import hazard_stall_controller_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer, so a load targeting it cannot create a dependence
  always_comb begin
    rs1_hit  = id_use_rs1 && (ex_rd == id_rs1);
    rs2_hit  = id_use_rs2 && (ex_rd == id_rs2);
    load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - stall/bubble/flush sequencer for hazards forwarding cannot cover
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32,
  parameter int unsigned MD_TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_is_muldiv,
  input  logic                   ex_redirect,
  input  logic                   md_done,
  input  logic                   mem_access,
  input  logic                   dmem_ready,
  output logic                   md_start,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_ex,
  output logic                   stall_mem,
  output logic                   flush_id,
  output logic                   bubble_ex,
  output logic                   bubble_mem,
  output logic                   bubble_wb,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   err_md_timeout
);

  localparam int TMR_W = $clog2(MD_TIMEOUT + 1);

  hsc_state_e             state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   err_q, err_d;
  hsc_ctrl_t              ctrl;
  logic                   timeout;
  logic                   load_use;

  hazard_load_use_detect u_lu (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Next state and same-cycle pipeline controls; a data-memory wait outranks everything
  // because the whole pipeline freezes and the other hazards get re-evaluated on release
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    timer_d = timer_q;
    timeout = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_access && !dmem_ready) begin
          ctrl.stall_if  = 1'b1;
          ctrl.stall_id  = 1'b1;
          ctrl.stall_ex  = 1'b1;
          ctrl.stall_mem = 1'b1;
          ctrl.bubble_wb = 1'b1;
          state_d        = ST_DMEM_WAIT;
        end else if (ex_is_muldiv && !md_done) begin
          ctrl.md_start   = 1'b1;
          ctrl.stall_if   = 1'b1;
          ctrl.stall_id   = 1'b1;
          ctrl.stall_ex   = 1'b1;
          ctrl.bubble_mem = 1'b1;
          state_d         = ST_MD_BUSY;
          timer_d         = TMR_W'(1);
        end else if (ex_redirect) begin
          ctrl.flush_id  = 1'b1;
          ctrl.bubble_ex = 1'b1;
        end else if (load_use) begin
          ctrl.stall_if  = 1'b1;
          ctrl.stall_id  = 1'b1;
          ctrl.bubble_ex = 1'b1;
        end
      end
      ST_DMEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl.stall_if  = 1'b1;
          ctrl.stall_id  = 1'b1;
          ctrl.stall_ex  = 1'b1;
          ctrl.stall_mem = 1'b1;
          ctrl.bubble_wb = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MD_BUSY: begin
        if (md_done) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_W'(MD_TIMEOUT)) begin
          // abandon the operation: the pipeline moves on with a bubble in place of the result
          timeout         = 1'b1;
          ctrl.bubble_mem = 1'b1;
          state_d         = ST_RUN;
          timer_d         = '0;
        end else begin
          ctrl.stall_if   = 1'b1;
          ctrl.stall_id   = 1'b1;
          ctrl.stall_ex   = 1'b1;
          ctrl.bubble_mem = 1'b1;
          timer_d         = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
    // controls must be quiet while reset is held, even if upstream inputs are not
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  // Saturating stall counter and sticky timeout flag
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.stall_if && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
    err_d = err_q | timeout;
  end

  // State, timer, counter and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign md_start       = ctrl.md_start;
  assign stall_if       = ctrl.stall_if;
  assign stall_id       = ctrl.stall_id;
  assign stall_ex       = ctrl.stall_ex;
  assign stall_mem      = ctrl.stall_mem;
  assign flush_id       = ctrl.flush_id;
  assign bubble_ex      = ctrl.bubble_ex;
  assign bubble_mem     = ctrl.bubble_mem;
  assign bubble_wb      = ctrl.bubble_wb;
  assign stall_cnt      = stall_cnt_q;
  assign err_md_timeout = err_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;

  localparam int CW = 4;

  // {md_start, stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_mem, bubble_wb}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b011000100;
  localparam logic [8:0] C_RD   = 9'b000001100;
  localparam logic [8:0] C_MDS  = 9'b111100010;
  localparam logic [8:0] C_MDB  = 9'b011100010;
  localparam logic [8:0] C_MW   = 9'b011110001;
  localparam logic [8:0] C_TO   = 9'b000000010;

  typedef struct {
    logic [8:0]    ctrl;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_is_muldiv, ex_redirect;
  logic          md_done, mem_access, dmem_ready;
  logic          md_start, stall_if, stall_id, stall_ex, stall_mem;
  logic          flush_id, bubble_ex, bubble_mem, bubble_wb;
  logic [CW-1:0] stall_cnt;
  logic          err_md_timeout;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.STALL_CNT_W(CW), .MD_TIMEOUT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_is_muldiv   (ex_is_muldiv),
    .ex_redirect    (ex_redirect),
    .md_done        (md_done),
    .mem_access     (mem_access),
    .dmem_ready     (dmem_ready),
    .md_start       (md_start),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .flush_id       (flush_id),
    .bubble_ex      (bubble_ex),
    .bubble_mem     (bubble_mem),
    .bubble_wb      (bubble_wb),
    .stall_cnt      (stall_cnt),
    .err_md_timeout (err_md_timeout)
  );

  // monitor: mid-cycle, pop the expectation issued for this cycle and compare
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {md_start, stall_if, stall_id, stall_ex, stall_mem,
             flush_id, bubble_ex, bubble_mem, bubble_wb};
      checks++;
      if (act !== e.ctrl || stall_cnt !== e.cnt || err_md_timeout !== e.err) begin
        errors++;
        $display("FAIL step%0d: ctrl=%b cnt=%0d err=%b, required ctrl=%b cnt=%0d err=%b",
                 step_no, act, stall_cnt, err_md_timeout, e.ctrl, e.cnt, e.err);
      end
      step_no++;
    end
  end

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_is_muldiv = 1'b0; ex_redirect = 1'b0; md_done = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  // issue one cycle: inputs are already set, push its expectation, advance to next cycle
  task automatic go(input logic [8:0] c, input logic [CW-1:0] n, input logic r);
    exp_t e;
    e.ctrl = c; e.cnt = n; e.err = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    @(posedge clk);
    #1;
    go(C_NONE, 0, 0);
    rst_n = 1'b1;
    go(C_NONE, 0, 0);

    // load-use on rs1, then released
    load_use_rs1(5'd5);
    go(C_LU, 0, 0);
    clear_in();
    go(C_NONE, 1, 0);
    // load to x0 never stalls
    load_use_rs1(5'd0);
    go(C_NONE, 1, 0);
    // load-use through rs2
    clear_in();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    go(C_LU, 1, 0);
    clear_in();
    go(C_NONE, 2, 0);
    // matching rs2 but not read
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    go(C_NONE, 2, 0);

    // redirect suppresses load-use
    clear_in();
    load_use_rs1(5'd5);
    ex_redirect = 1'b1;
    go(C_RD, 2, 0);
    clear_in();
    go(C_NONE, 2, 0);

    // mul/div finishing after 5 cycles
    ex_is_muldiv = 1'b1;
    go(C_MDS, 2, 0);
    go(C_MDB, 3, 0);
    go(C_MDB, 4, 0);
    go(C_MDB, 5, 0);
    go(C_MDB, 6, 0);
    md_done = 1'b1;
    go(C_NONE, 7, 0);
    ex_is_muldiv = 1'b0; md_done = 1'b0;
    go(C_NONE, 7, 0);
    // single-cycle mul/div
    ex_is_muldiv = 1'b1; md_done = 1'b1;
    go(C_NONE, 7, 0);
    // md_done together with redirect: redirect acted on next cycle
    md_done = 1'b0;
    go(C_MDS, 7, 0);
    go(C_MDB, 8, 0);
    ex_is_muldiv = 1'b0; md_done = 1'b1; ex_redirect = 1'b1;
    go(C_NONE, 9, 0);
    md_done = 1'b0;
    go(C_RD, 9, 0);
    clear_in();
    go(C_NONE, 9, 0);

    // dmem wait of 3 cycles with a redirect arriving during the wait
    mem_access = 1'b1;
    go(C_MW, 9, 0);
    ex_redirect = 1'b1;
    go(C_MW, 10, 0);
    go(C_MW, 11, 0);
    dmem_ready = 1'b1;
    go(C_NONE, 12, 0);
    mem_access = 1'b0; dmem_ready = 1'b0;
    go(C_RD, 12, 0);
    clear_in();
    go(C_NONE, 12, 0);
    // dmem wait outranks mul/div, which starts after release
    mem_access = 1'b1; ex_is_muldiv = 1'b1;
    go(C_MW, 12, 0);
    dmem_ready = 1'b1;
    go(C_NONE, 13, 0);
    mem_access = 1'b0; dmem_ready = 1'b0;
    go(C_MDS, 13, 0);
    md_done = 1'b1;
    go(C_NONE, 14, 0);
    // completed memory access does not block load-use
    clear_in();
    mem_access = 1'b1; dmem_ready = 1'b1;
    load_use_rs1(5'd9);
    go(C_LU, 14, 0);
    clear_in();
    go(C_NONE, 15, 0);

    // mul/div timeout with counter saturated at 15
    ex_is_muldiv = 1'b1;
    go(C_MDS, 15, 0);
    for (int i = 0; i < 7; i++) go(C_MDB, 15, 0);
    ex_is_muldiv = 1'b0;
    go(C_TO, 15, 0);
    go(C_NONE, 15, 1);
    go(C_NONE, 15, 1);

    // async reset in the middle of MD_BUSY
    ex_is_muldiv = 1'b1;
    go(C_MDS, 15, 1);
    go(C_MDB, 15, 1);
    rst_n = 1'b0;
    go(C_NONE, 0, 0);
    rst_n = 1'b1;
    ex_is_muldiv = 1'b0;
    go(C_NONE, 0, 0);
    ex_is_muldiv = 1'b1;
    go(C_MDS, 0, 0);
    md_done = 1'b1;
    go(C_NONE, 1, 0);
    clear_in();
    go(C_NONE, 1, 0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
